// File: rtl/xc_malu_divrem_if.sv
// Request/response bundle between the MALU issue logic and the sequential divider.
// valid/ready: requester holds valid and operands stable until a one-cycle ready pulse; flush aborts.
interface xc_malu_divrem_if;
  logic        flush;
  logic        valid;
  logic        op_signed;
  logic        op_rem;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        ready;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  modport master (
    output flush, valid, op_signed, op_rem, rs1, rs2,
    input  busy, ready, result, dbg_state
  );

  modport slave (
    input  flush, valid, op_signed, op_rem, rs1, rs2,
    output busy, ready, result, dbg_state
  );
endinterface

// File: rtl/xc_malu_divrem_seq.sv
// Iterative restoring divider (div/divu/rem/remu), one quotient bit per cycle.
// Operates on magnitudes; signs are applied once when the result is registered on entry to DONE.
module xc_malu_divrem_seq #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  xc_malu_divrem_if.slave    bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] div_q, div_d;
  logic [4:0]  count_q, count_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic        op_rem_q, op_rem_d;
  logic [31:0] result_q, result_d;

  logic [31:0] abs_a, abs_b;
  logic        div0, ovf;
  logic [32:0] t, d;

  assign abs_a = (bus.op_signed && bus.rs1[31]) ? (32'd0 - bus.rs1) : bus.rs1;
  assign abs_b = (bus.op_signed && bus.rs2[31]) ? (32'd0 - bus.rs2) : bus.rs2;
  assign div0  = (bus.rs2 == 32'd0);
  assign ovf   = bus.op_signed && (bus.rs1 == 32'h8000_0000) && (bus.rs2 == 32'hFFFF_FFFF);

  assign t = {rem_q, quo_q[31]};
  assign d = t - {1'b0, div_q};

  always_comb begin
    state_d  = state_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    div_d    = div_q;
    count_d  = count_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    op_rem_d = op_rem_q;
    result_d = result_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.valid) begin
            op_rem_d = bus.op_rem;
            div_d    = abs_b;
            rem_d    = 32'd0;
            count_d  = 5'd0;
            neg_q_d  = bus.op_signed && (bus.rs1[31] ^ bus.rs2[31]) && !div0;
            neg_r_d  = bus.op_signed && bus.rs1[31];
            // Presets are chosen so the common sign-fixup in DONE yields the architectural result.
            if (EARLY_OUT && div0) begin
              quo_d   = 32'hFFFF_FFFF;
              rem_d   = abs_a;
              state_d = S_DONE;
            end else if (EARLY_OUT && ovf) begin
              quo_d   = 32'h8000_0000;
              state_d = S_DONE;
            end else begin
              quo_d   = abs_a;
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!d[32]) begin
            rem_d = d[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = t[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    // Register the result as DONE is entered so it is valid in the ready cycle.
    if (state_d == S_DONE && state_q != S_DONE) begin
      if (op_rem_d) result_d = neg_r_d ? (32'd0 - rem_d) : rem_d;
      else          result_d = neg_q_d ? (32'd0 - quo_d) : quo_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      div_q    <= 32'd0;
      count_q  <= 5'd0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      op_rem_q <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      count_q  <= count_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      op_rem_q <= op_rem_d;
      result_q <= result_d;
    end
  end

  assign bus.ready     = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_xc_malu_divrem_seq.sv
// Bench for the sequential divider: directed vector table, multi-cycle corner sequences
// (flush, reset, back-to-back) and random ops against a behavioural reference.
module tb_xc_malu_divrem_seq;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  xc_malu_divrem_if m0 ();
  xc_malu_divrem_if m1 ();

  xc_malu_divrem_seq #(.EARLY_OUT(1'b1)) dut0 (.clock(clock), .reset(reset), .bus(m0.slave));
  xc_malu_divrem_seq #(.EARLY_OUT(1'b0)) dut1 (.clock(clock), .reset(reset), .bus(m1.slave));

  typedef struct {
    logic        s;
    logic        r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int last_gap = 0;
  logic [31:0] last_exp0 = 32'd0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(int which, logic v, logic s, logic r, logic [31:0] a, logic [31:0] b);
    if (which == 0) begin
      m0.valid = v; m0.op_signed = s; m0.op_rem = r; m0.rs1 = a; m0.rs2 = b;
    end else begin
      m1.valid = v; m1.op_signed = s; m1.op_rem = r; m1.rs1 = a; m1.rs2 = b;
    end
  endtask

  function automatic logic get_ready(int which);
    return (which == 0) ? m0.ready : m1.ready;
  endfunction
  function automatic logic get_busy(int which);
    return (which == 0) ? m0.busy : m1.busy;
  endfunction
  function automatic logic [31:0] get_result(int which);
    return (which == 0) ? m0.result : m1.result;
  endfunction

  function automatic logic [31:0] ref_model(logic s, logic r, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
      return r ? 32'(sa % sb) : 32'(sa / sb);
    end
    return r ? (a % b) : (a / b);
  endfunction

  function automatic int exp_latency(int which, logic s, logic [31:0] a, logic [31:0] b);
    if (which == 0 && (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Drives one request at a negedge, then waits (bounded) for the ready pulse.
  task automatic issue(int which, logic s, logic r, logic [31:0] a, logic [31:0] b,
                       logic [31:0] exp, bit keep, string name);
    int k_busy;
    bit got;
    @(negedge clock);
    drive(which, 1'b1, s, r, a, b);
    exp_q.push_back(exp);
    k_busy = 0;
    got = 1'b0;
    for (int k = 1; k <= 80 && !got; k++) begin
      @(posedge clock);
      #1;
      if (k_busy == 0 && get_busy(which)) k_busy = k;
      if (get_ready(which)) begin
        got = 1'b1;
        check(name, get_result(which), exp_q.pop_front());
        check({name, "_lat"}, 32'(k - k_busy + 1), 32'(exp_latency(which, s, a, b)));
        last_gap = k_busy;
        if (which == 0) last_exp0 = exp;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no ready expected ready within 80 cycles", name);
      void'(exp_q.pop_front());
    end
    if (!keep) begin
      @(negedge clock);
      drive(which, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
  endtask

  vec_t vecs[10];
  int   rdy_cnt;
  logic rs, rr;
  logic [31:0] ra, rb;

  initial begin
    m0.flush = 1'b0; m1.flush = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    vecs[0] = '{1'b0, 1'b0, 32'd100,          32'd7,          32'd14};
    vecs[1] = '{1'b0, 1'b1, 32'd100,          32'd7,          32'd2};
    vecs[2] = '{1'b1, 1'b0, 32'hFFFF_FFF9,    32'd2,          32'hFFFF_FFFD};
    vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFF9,    32'd2,          32'hFFFF_FFFF};
    vecs[4] = '{1'b1, 1'b1, 32'd7,            32'hFFFF_FFFE,  32'd1};
    vecs[5] = '{1'b1, 1'b0, 32'd5,            32'd0,          32'hFFFF_FFFF};
    vecs[6] = '{1'b1, 1'b1, 32'd5,            32'd0,          32'd5};
    vecs[7] = '{1'b1, 1'b0, 32'h8000_0000,    32'hFFFF_FFFF,  32'h8000_0000};
    vecs[8] = '{1'b1, 1'b1, 32'h8000_0000,    32'hFFFF_FFFF,  32'd0};
    vecs[9] = '{1'b0, 1'b0, 32'hFFFF_FFFF,    32'd1,          32'hFFFF_FFFF};

    repeat (3) @(posedge clock);
    #1;
    check("reset_result", m0.result, 32'd0);
    check("reset_ready",  {31'd0, m0.ready}, 32'd0);
    check("reset_busy",   {31'd0, m0.busy}, 32'd0);
    check("reset_state",  {30'd0, m0.dbg_state}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) issue(0, vecs[i].s, vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
    for (int i = 5; i <= 8; i++) issue(1, vecs[i].s, vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, $sformatf("noearly_vec%0d", i));

    // Back-to-back: valid held across ready, next op accepted in the following cycle.
    issue(0, 1'b0, 1'b0, 32'd1000, 32'd10, 32'd100, 1'b1, "b2b_first");
    issue(0, 1'b0, 1'b1, 32'd1001, 32'd10, 32'd1, 1'b0, "b2b_second");
    check("b2b_gap", 32'(last_gap), 32'd2);

    // Flush at RUN count 10.
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    @(posedge clock);
    repeat (10) @(posedge clock);
    @(negedge clock);
    m0.flush = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clock);
    #1;
    check("flush_busy",  {31'd0, m0.busy}, 32'd0);
    check("flush_ready", {31'd0, m0.ready}, 32'd0);
    @(negedge clock);
    m0.flush = 1'b0;
    rdy_cnt = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (m0.ready) rdy_cnt++;
    end
    check("flush_no_ready", 32'(rdy_cnt), 32'd0);
    check("flush_result_kept", m0.result, last_exp0);
    issue(0, 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 1'b0, "after_flush");

    // Flush beats valid in IDLE.
    @(negedge clock);
    m0.flush = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0, 32'd50, 32'd5);
    @(posedge clock);
    #1;
    check("flush_prio_busy", {31'd0, m0.busy}, 32'd0);
    @(negedge clock);
    m0.flush = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset during RUN.
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 1'b0, 32'd77, 32'd5);
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clock);
    #1;
    check("rst_run_ready",  {31'd0, m0.ready}, 32'd0);
    check("rst_run_busy",   {31'd0, m0.busy}, 32'd0);
    check("rst_run_result", m0.result, 32'd0);
    check("rst_run_result1", m1.result, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Random ops on both configurations.
    for (int i = 0; i < 360; i++) begin
      int which;
      int mode;
      which = (i % 6 == 5) ? 1 : 0;
      mode  = $urandom_range(0, 7);
      rs = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      ra = $urandom();
      rb = $urandom();
      if (mode == 0) rb = 32'd0;
      else if (mode == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (mode == 2) rb = 32'($urandom_range(1, 17));
      else if (mode == 3) rb = 32'd0 - 32'($urandom_range(1, 17));
      issue(which, rs, rr, ra, rb, ref_model(rs, rr, ra, rb), 1'b0, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
